mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Multi-cycle control FSM for the MIPS datapath. It sits directly upstream of RegisterFile and produces its RegWre and RegDst, plus all other datapath strobes (PC, IR, ALU, data memory, write-back mux).
- Decodes op/funct from the instruction register. Sequences each instruction through IF/ID/EXE/MEM/WB states.

Parameters:
- HALT_OP, 6'b111111, opcode that parks the FSM in HALT.
- JAL_REG_SEL, 2'b00, RegDst code that selects $31.

Ports:
- CLK  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag from the current cycle
- PCWre  out  1  PC load enable
- IRWre  out  1  instruction register load
- InsMemRW  out  1  instruction memory read
- RegWre  out  1  RegisterFile write enable
- RegDst  out  2  00=$31, 01=rt, 10=rd
- WrRegDSrc  out  1  0=PC+4, 1=DB
- ALUSrcA  out  1  1=sa (sll)
- ALUSrcB  out  1  1=extended immediate
- ExtSel  out  1  1=sign-extend, 0=zero-extend
- ALUOp  out  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 101 slt
- mRD  out  1  data memory read
- mWR  out  1  data memory write
- DBDataSrc  out  1  1=memory data, 0=ALU result
- PCSrc  out  2  00 PC+4, 01 branch target, 10 rs (jr), 11 jump target
- state  out  4  current state, for debug

Behaviour:
- State register is the only flop. It resets asynchronously to IF when Reset=0. All outputs are combinational from state, op, funct and zero.
- While Reset=0: PCWre, IRWre, RegWre, mWR and mRD are forced to 0, and all other outputs are 0.
- State encodings: IF=0, ID=1, EXE_AL=2, WB_AL=3, EXE_B=4, EXE_LS=5, MEM=6, WB_LD=7, HALT=8. Codes 9–15 go to IF on the next edge.
- IF: InsMemRW=1, IRWre=1. Next state is ID.
- ID, branching on op:
  - R-type (op=000000) with funct=001000 (jr): PCSrc=10, PCWre=1, next IF.
  - j (000010): PCSrc=11, PCWre=1, next IF.
  - jal (000011): PCSrc=11, PCWre=1, RegWre=1, RegDst=JAL_REG_SEL, WrRegDSrc=0, next IF.
  - HALT_OP: next HALT.
  - beq (000100) and bne (000101): next EXE_B.
  - lw (100011) and sw (101011): next EXE_LS.
  - R-type ALU ops and addi (001000), ori (001101): next EXE_AL.
  - Any other opcode, or R-type with an unlisted funct: PCWre=1, PCSrc=00, no writes, next IF (treated as a nop).
- EXE_AL, next WB_AL:
  - R-type ALU ops by funct: add 100000 -> ALUOp 000; sub 100010 -> 001; and 100100 -> 100; or 100101 -> 011; slt 101010 -> 101; sll 000000 -> 010 with ALUSrcA=1.
  - addi: ALUSrcB=1, ExtSel=1, ALUOp 000.
  - ori: ALUSrcB=1, ExtSel=0, ALUOp 011.
- WB_AL: same ALU controls as EXE_AL. RegWre=1, WrRegDSrc=1, DBDataSrc=0, RegDst=10 for R-type and 01 for I-type. PCWre=1, PCSrc=00, next IF.
- EXE_B: ALUOp=001, PCWre=1.
  - PCSrc=01 when (beq and zero=1) or (bne and zero=0); otherwise 00.
  - Next IF.
- EXE_LS: ALUSrcB=1, ExtSel=1, ALUOp=000, next MEM.
- MEM: ALU controls held as in EXE_LS.
  - lw: mRD=1, next WB_LD.
  - sw: mWR=1, PCWre=1, PCSrc=00, next IF.
- WB_LD: mRD=1, DBDataSrc=1, RegWre=1, RegDst=01, WrRegDSrc=1, PCWre=1, PCSrc=00, next IF.
- HALT: all enables 0. The FSM stays in HALT until Reset is asserted.
- Cycle counts, IF through the PCWre cycle inclusive:
  - j/jal/jr: 2
  - beq/bne: 3
  - R-type/addi/ori/sw: 4
  - lw: 5
- Invariants:
  - Exactly one PCWre=1 cycle per instruction.
  - RegWre and mWR never both 1.
  - No enable asserted in IF except IRWre and InsMemRW.
- Reset asserted mid-instruction: state returns to IF immediately and asynchronously; the pending write is dropped.

Test Plan:
- Reset=0 for 2 cycles, then release; op=000000, funct=100000 (add) -> states 0,1,2,3,0. RegWre=1 and RegDst=10 only in state 3, ALUOp=000, PCWre=1 only in state 3.
- lw (op=100011) -> states 0,1,5,6,7,0. mRD=1 in states 6–7, RegWre=1 with DBDataSrc=1 and RegDst=01 in state 7. Then sw (101011) -> states 0,1,5,6,0 with mWR=1 only in state 6 and RegWre never 1.
- beq with zero=1 -> PCSrc=01 in EXE_B. beq with zero=0 -> PCSrc=00. bne with zero=0 -> PCSrc=01. Each takes 3 cycles.
- jal -> 2 cycles; in ID: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11. jr (funct=001000) -> PCSrc=10 and RegWre=0.
- op=111111 -> state 8 held for 20 cycles with all enables 0. Reset pulse -> state 0.
- Reset driven low during WB_AL between clock edges -> state=0 and RegWre=0 without waiting for a clock edge. Undefined op=010001 -> nop in 2 cycles, no writes.

Source files
------------

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle MIPS control FSM driving PC/IR/ALU/memory/register-file strobes
`timescale 1ns/1ps
module mc_control_unit #(
  parameter logic [5:0] HALT_OP     = 6'b111111,
  parameter logic [1:0] JAL_REG_SEL = 2'b00
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [2:0] ALUOp,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc,
  output logic [1:0] PCSrc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    ST_IF     = 4'd0,
    ST_ID     = 4'd1,
    ST_EXE_AL = 4'd2,
    ST_WB_AL  = 4'd3,
    ST_EXE_B  = 4'd4,
    ST_EXE_LS = 4'd5,
    ST_MEM    = 4'd6,
    ST_WB_LD  = 4'd7,
    ST_HALT   = 4'd8
  } stateT;

  stateT stateQ;
  stateT stateD;

  logic isRType, isJr, isJ, isJal, isHalt, isBeq, isBne, isLw, isSw, isAddi, isOri, rAluFn;
  logic aluSrcAAl, aluSrcBAl, extSelAl;
  logic [2:0] aluOpAl;

  assign isRType = (op == 6'b000000);
  assign isJr    = isRType && (funct == 6'b001000);
  assign isJ     = (op == 6'b000010);
  assign isJal   = (op == 6'b000011);
  assign isHalt  = (op == HALT_OP);
  assign isBeq   = (op == 6'b000100);
  assign isBne   = (op == 6'b000101);
  assign isLw    = (op == 6'b100011);
  assign isSw    = (op == 6'b101011);
  assign isAddi  = (op == 6'b001000);
  assign isOri   = (op == 6'b001101);
  assign rAluFn  = (funct == 6'b100000) || (funct == 6'b100010) || (funct == 6'b100100) ||
                   (funct == 6'b100101) || (funct == 6'b101010) || (funct == 6'b000000);

  // State register: the only flop; asynchronous return to IF on reset.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) stateQ <= ST_IF;
    else        stateQ <= stateD;
  end

  // ALU controls for the ALU-class instructions, shared by EXE_AL and WB_AL.
  always_comb begin
    aluSrcAAl = 1'b0;
    aluSrcBAl = 1'b0;
    extSelAl  = 1'b0;
    aluOpAl   = 3'b000;
    if (isRType) begin
      case (funct)
        6'b100010: aluOpAl = 3'b001;
        6'b100100: aluOpAl = 3'b100;
        6'b100101: aluOpAl = 3'b011;
        6'b101010: aluOpAl = 3'b101;
        6'b000000: begin
          aluOpAl   = 3'b010;
          aluSrcAAl = 1'b1;
        end
        default:   aluOpAl = 3'b000;
      endcase
    end else if (isOri) begin
      aluSrcBAl = 1'b1;
      aluOpAl   = 3'b011;
    end else begin
      aluSrcBAl = 1'b1;
      extSelAl  = 1'b1;
    end
  end

  // Next-state and strobe decode; everything held at 0 while reset is asserted.
  always_comb begin
    stateD    = ST_IF;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = 3'b000;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    PCSrc     = 2'b00;
    state     = 4'd0;
    if (Reset) begin
      state = stateQ;
      case (stateQ)
        ST_IF: begin
          InsMemRW = 1'b1;
          IRWre    = 1'b1;
          stateD   = ST_ID;
        end
        ST_ID: begin
          if (isJr) begin
            PCSrc = 2'b10;
            PCWre = 1'b1;
          end else if (isJ) begin
            PCSrc = 2'b11;
            PCWre = 1'b1;
          end else if (isJal) begin
            PCSrc  = 2'b11;
            PCWre  = 1'b1;
            RegWre = 1'b1;
            RegDst = JAL_REG_SEL;
          end else if (isHalt) begin
            stateD = ST_HALT;
          end else if (isBeq || isBne) begin
            stateD = ST_EXE_B;
          end else if (isLw || isSw) begin
            stateD = ST_EXE_LS;
          end else if ((isRType && rAluFn) || isAddi || isOri) begin
            stateD = ST_EXE_AL;
          end else begin
            PCWre = 1'b1;
          end
        end
        ST_EXE_AL, ST_WB_AL: begin
          ALUSrcA = aluSrcAAl;
          ALUSrcB = aluSrcBAl;
          ExtSel  = extSelAl;
          ALUOp   = aluOpAl;
          if (stateQ == ST_EXE_AL) begin
            stateD = ST_WB_AL;
          end else begin
            RegWre    = 1'b1;
            WrRegDSrc = 1'b1;
            RegDst    = isRType ? 2'b10 : 2'b01;
            PCWre     = 1'b1;
          end
        end
        ST_EXE_B: begin
          ALUOp = 3'b001;
          PCWre = 1'b1;
          if ((isBeq && zero) || (isBne && !zero)) PCSrc = 2'b01;
        end
        ST_EXE_LS, ST_MEM: begin
          ALUSrcB = 1'b1;
          ExtSel  = 1'b1;
          if (stateQ == ST_EXE_LS) begin
            stateD = ST_MEM;
          end else if (isLw) begin
            mRD    = 1'b1;
            stateD = ST_WB_LD;
          end else begin
            mWR   = 1'b1;
            PCWre = 1'b1;
          end
        end
        ST_WB_LD: begin
          mRD       = 1'b1;
          DBDataSrc = 1'b1;
          RegWre    = 1'b1;
          RegDst    = 2'b01;
          WrRegDSrc = 1'b1;
          PCWre     = 1'b1;
        end
        ST_HALT: stateD = ST_HALT;
        default: stateD = ST_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - randomized self-checking bench for mc_control_unit
`timescale 1ns/1ps
module tb_mc_control_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel;
  logic       mRD, mWR, DBDataSrc;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp;
  logic [3:0] state;

  mc_control_unit dut (
    .CLK(CLK), .Reset(Reset), .op(op), .funct(funct), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
    .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc),
    .PCSrc(PCSrc), .state(state)
  );

  always #10 CLK = ~CLK;

  typedef struct packed {
    logic       pcWre, irWre, insMemRw, regWre;
    logic [1:0] regDst;
    logic       wrRegDSrc, aluSrcA, aluSrcB, extSel;
    logic [2:0] aluOp;
    logic       mRd, mWr, dbDataSrc;
    logic [1:0] pcSrc;
    logic [3:0] st;
  } outT;

  localparam int C_JR = 0, C_J = 1, C_JAL = 2, C_BEQ = 3, C_BNE = 4;
  localparam int C_LW = 5, C_SW = 6, C_AL = 7, C_HALT = 8, C_NOP = 9;

  int nCmp = 0;
  int nFail = 0;
  int cls = 0;
  int step = 0;
  bit chkEn = 1'b0;

  function automatic int classify(logic [5:0] o, logic [5:0] f);
    case (o)
      6'h00: begin
        if (f == 6'h08) return C_JR;
        if (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2a || f == 6'h00)
          return C_AL;
        return C_NOP;
      end
      6'h02: return C_J;
      6'h03: return C_JAL;
      6'h04: return C_BEQ;
      6'h05: return C_BNE;
      6'h23: return C_LW;
      6'h2b: return C_SW;
      6'h08, 6'h0d: return C_AL;
      6'h3f: return C_HALT;
      default: return C_NOP;
    endcase
  endfunction

  function automatic int lenOf(int c);
    case (c)
      C_BEQ, C_BNE: return 3;
      C_AL, C_SW:   return 4;
      C_LW:         return 5;
      C_HALT:       return 22;
      default:      return 2;
    endcase
  endfunction

  // {ALUSrcA, ALUSrcB, ExtSel, ALUOp} for an ALU-class instruction.
  function automatic logic [5:0] aluRef(logic [5:0] o, logic [5:0] f);
    if (o == 6'h08) return 6'b011000;
    if (o == 6'h0d) return 6'b010011;
    case (f)
      6'h22:   return 6'b000001;
      6'h24:   return 6'b000100;
      6'h25:   return 6'b000011;
      6'h2a:   return 6'b000101;
      6'h00:   return 6'b100010;
      default: return 6'b000000;
    endcase
  endfunction

  // Expected outputs at cycle s (0 = IF) of an instruction of class c.
  function automatic outT model(int c, int s, logic [5:0] o, logic [5:0] f, logic z);
    outT m;
    m = '0;
    case (c)
      C_BEQ, C_BNE: m.st = (s < 2) ? 4'(s) : 4'd4;
      C_AL:         m.st = 4'(s);
      C_LW, C_SW:   m.st = (s < 2) ? 4'(s) : 4'(s + 3);
      C_HALT:       m.st = (s < 2) ? 4'(s) : 4'd8;
      default:      m.st = 4'(s);
    endcase
    if (s == 0) begin
      m.irWre = 1'b1;
      m.insMemRw = 1'b1;
      return m;
    end
    case (c)
      C_JR:  begin m.pcWre = 1'b1; m.pcSrc = 2'b10; end
      C_J:   begin m.pcWre = 1'b1; m.pcSrc = 2'b11; end
      C_JAL: begin m.pcWre = 1'b1; m.pcSrc = 2'b11; m.regWre = 1'b1; m.regDst = 2'b00; end
      C_NOP: m.pcWre = 1'b1;
      C_BEQ, C_BNE: if (s == 2) begin
        m.aluOp = 3'b001;
        m.pcWre = 1'b1;
        if (c == C_BEQ) m.pcSrc = z ? 2'b01 : 2'b00;
        else            m.pcSrc = z ? 2'b00 : 2'b01;
      end
      C_AL: if (s >= 2) begin
        {m.aluSrcA, m.aluSrcB, m.extSel, m.aluOp} = aluRef(o, f);
        if (s == 3) begin
          m.regWre = 1'b1;
          m.wrRegDSrc = 1'b1;
          m.regDst = (o == 6'h00) ? 2'b10 : 2'b01;
          m.pcWre = 1'b1;
        end
      end
      C_LW, C_SW: begin
        if (s == 2 || s == 3) begin
          m.aluSrcB = 1'b1;
          m.extSel = 1'b1;
        end
        if (s == 3) begin
          if (c == C_LW) m.mRd = 1'b1;
          else begin m.mWr = 1'b1; m.pcWre = 1'b1; end
        end
        if (s == 4) begin
          m.mRd = 1'b1; m.dbDataSrc = 1'b1; m.regWre = 1'b1;
          m.regDst = 2'b01; m.wrRegDSrc = 1'b1; m.pcWre = 1'b1;
        end
      end
      default: ;
    endcase
    return m;
  endfunction

  function automatic outT dutOut();
    outT g;
    g = {PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel,
         ALUOp, mRD, mWR, DBDataSrc, PCSrc, state};
    return g;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Per-cycle comparison of all DUT outputs against the instruction-level model.
  always @(negedge CLK) begin : cmpProc
    outT e, g;
    if (chkEn) begin
      e = model(cls, step, op, funct, zero);
      g = dutOut();
      nCmp++;
      if (g !== e) begin
        nFail++;
        $display("FAIL cycle t=%0t op=%h funct=%h zero=%b step=%0d: got %h expected %h",
                 $time, op, funct, zero, step, g, e);
      end
      nCmp++;
      if ((RegWre & mWR) !== 1'b0) begin
        nFail++;
        $display("FAIL regwre_mwr_exclusive t=%0t: got RegWre=%b mWR=%b required not both 1",
                 $time, RegWre, mWR);
      end
    end
  end

  // Runs one instruction starting just after the edge that entered IF.
  task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input int zm,
                          input int abortAt, output int dutLen);
    int len, pcw;
    op = o;
    funct = f;
    cls = classify(o, f);
    len = lenOf(cls);
    dutLen = 0;
    pcw = 0;
    step = 0;
    zero = (zm == 2) ? 1'($urandom_range(0, 1)) : (zm == 1);
    chkEn = 1'b1;
    for (int s = 0; s < len; s++) begin
      step = s;
      if (s == abortAt) begin
        chkEn = 1'b0;
        #1 Reset = 1'b0;
        #1;
        check("async_reset_state", 32'(state), 32'd0);
        check("async_reset_regwre", 32'(RegWre), 32'd0);
        #2 Reset = 1'b1;
        #1;
        check("post_reset_state_if", 32'(state), 32'd0);
        check("post_reset_irwre", 32'(IRWre), 32'd1);
        return;
      end
      @(negedge CLK);
      if (PCWre === 1'b1) begin
        pcw++;
        if (dutLen == 0) dutLen = s + 1;
      end
      @(posedge CLK);
      #1;
      if (zm == 2) zero = 1'($urandom_range(0, 1));
    end
    check("pcwre_count", 32'(pcw), (cls == C_HALT) ? 32'd0 : 32'd1);
  endtask

  logic [5:0] dOp    [16] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h04, 6'h05, 6'h03, 6'h00,
                              6'h11, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0d, 6'h05};
  logic [5:0] dFunct [16] = '{6'h20, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08,
                              6'h00, 6'h22, 6'h24, 6'h25, 6'h00, 6'h00, 6'h00, 6'h00};
  int dZero [16] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  int dLen  [16] = '{4, 5, 4, 3, 3, 3, 2, 2, 2, 4, 4, 4, 4, 4, 4, 3};
  logic [5:0] rOps [12] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h2b,
                            6'h08, 6'h0d, 6'h11, 6'h00};
  logic [5:0] rFns [8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h08, 6'h00};

  initial begin
    int n;
    outT m;
    logic [5:0] o, f;
    Reset = 1'b0;
    op = 6'h00;
    funct = 6'h00;
    zero = 1'b0;

    repeat (2) begin
      @(negedge CLK);
      check("reset_outputs", 32'(dutOut()), 32'd0);
    end
    @(posedge CLK);
    #1 Reset = 1'b1;

    m = model(C_AL, 3, 6'h00, 6'h20, 1'b0);
    check("model_add_wb_state", 32'(m.st), 32'd3);
    check("model_add_wb_regdst", 32'(m.regDst), 32'd2);
    m = model(C_BEQ, 2, 6'h04, 6'h00, 1'b1);
    check("model_beq_taken", 32'(m.pcSrc), 32'd1);
    m = model(C_BNE, 2, 6'h05, 6'h00, 1'b0);
    check("model_bne_taken", 32'(m.pcSrc), 32'd1);
    m = model(C_JAL, 1, 6'h03, 6'h00, 1'b0);
    check("model_jal_id", 32'({m.regWre, m.regDst, m.wrRegDSrc, m.pcSrc}), 32'b10_0011);
    m = model(C_AL, 2, 6'h00, 6'h00, 1'b0);
    check("model_sll_alu", 32'({m.aluSrcA, m.aluOp}), 32'b1010);
    check("model_undef_nop", 32'(classify(6'h11, 6'h00)), 32'(C_NOP));

    for (int i = 0; i < 16; i++) begin
      runInstr(dOp[i], dFunct[i], dZero[i], -1, n);
      check($sformatf("cycles_op%h_fn%h", dOp[i], dFunct[i]), 32'(n), 32'(dLen[i]));
    end

    runInstr(6'h00, 6'h20, 0, 3, n);

    runInstr(6'h3f, 6'h00, 2, -1, n);
    check("halt_held", 32'(state), 32'd8);
    chkEn = 1'b0;
    Reset = 1'b0;
    #1;
    check("halt_reset_state", 32'(state), 32'd0);
    @(posedge CLK);
    #1 Reset = 1'b1;

    for (int i = 0; i < 300; i++) begin
      o = rOps[$urandom_range(0, 11)];
      if (i % 12 == 11) begin
        o = 6'($urandom);
        if (o == 6'h3f) o = 6'h11;
      end
      f = (o == 6'h00) ? rFns[$urandom_range(0, 7)] : 6'($urandom);
      if (o == 6'h00 && $urandom_range(0, 7) == 0) f = 6'($urandom);
      runInstr(o, f, 2, -1, n);
    end

    chkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
